// File: rtl/core_pipe_decode_latch_pkg.sv
// rtl/core_pipe_decode_latch_pkg.sv - shared trap cause codes, widths and stage-2 state encoding
package core_pipe_decode_latch_pkg;

    localparam int CORE_XL           = 63;
    localparam int CORE_TRAP_CAUSE_W = 6;

    // mcause codes shared with execute and CSR logic
    localparam int TRAP_IACCESS = 1;
    localparam int TRAP_ILLEGAL = 2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_HALT  = 2'd2
    } s2_state_e;

endpackage

// File: rtl/core_pipe_decode_latch_if.sv
// rtl/core_pipe_decode_latch_if.sv - fetch-side and stage-2-side signals of the decode entry latch
interface core_pipe_decode_latch_if #(
    parameter int XL           = 63,
    parameter int TRAP_CAUSE_W = 6
);
    logic                    s1_i16bit;
    logic                    s1_i32bit;
    logic [31:0]             s1_instr;
    logic [XL:0]             s1_pc;
    logic [XL:0]             s1_npc;
    logic [1:0]              s1_ferr;
    logic                    s1_eat_2;
    logic                    s1_eat_4;

    logic                    s2_valid;
    logic                    s2_ready;
    logic [31:0]             s2_instr;
    logic [XL:0]             s2_pc;
    logic [XL:0]             s2_npc;
    logic                    s2_i16bit;
    logic                    s2_trap;
    logic [TRAP_CAUSE_W-1:0] s2_trap_cause;

    modport master (
        output s1_i16bit, s1_i32bit, s1_instr, s1_pc, s1_npc, s1_ferr, s2_ready,
        input  s1_eat_2, s1_eat_4, s2_valid, s2_instr, s2_pc, s2_npc,
               s2_i16bit, s2_trap, s2_trap_cause
    );

    modport slave (
        input  s1_i16bit, s1_i32bit, s1_instr, s1_pc, s1_npc, s1_ferr, s2_ready,
        output s1_eat_2, s1_eat_4, s2_valid, s2_instr, s2_pc, s2_npc,
               s2_i16bit, s2_trap, s2_trap_cause
    );

endinterface

// File: rtl/core_pipe_decode_latch_predecode.sv
// rtl/core_pipe_decode_latch_predecode.sv - combinational trap pre-classification (CORE_RVC_EN selects
// whether 16-bit instructions are legal)
module core_pipe_predecode
    import core_pipe_decode_latch_pkg::*;
#(
    parameter int TRAP_CAUSE_W = CORE_TRAP_CAUSE_W
) (
    input  logic [15:0]             instr_i,
    input  logic                    i16bit_i,
    input  logic [1:0]              ferr_i,
    output logic                    trap_o,
    output logic [TRAP_CAUSE_W-1:0] cause_o
);

`ifdef CORE_RVC_EN
    logic illegal16;
    assign illegal16 = (instr_i == 16'h0000);
`else
    // Without RVC every compressed encoding traps, but fetch must still drain it
    logic illegal16;
    logic unused_instr;
    assign illegal16    = 1'b1;
    assign unused_instr = ^instr_i;
`endif

    always_comb begin
        trap_o  = 1'b0;
        cause_o = '0;
        if (i16bit_i) begin
            // Only the low halfword belongs to a 16-bit instruction
            if (ferr_i[0]) begin
                trap_o  = 1'b1;
                cause_o = TRAP_CAUSE_W'(TRAP_IACCESS);
            end else if (illegal16) begin
                trap_o  = 1'b1;
                cause_o = TRAP_CAUSE_W'(TRAP_ILLEGAL);
            end
        end else if (|ferr_i) begin
            trap_o  = 1'b1;
            cause_o = TRAP_CAUSE_W'(TRAP_IACCESS);
        end
    end

endmodule

// File: rtl/core_pipe_decode_latch.sv
// rtl/core_pipe_decode_latch.sv - stage-2 entry register: drains fetch, holds one pre-classified
// instruction, halts after a trap until flush (16-bit legality set by CORE_RVC_EN)
module core_pipe_decode_latch
    import core_pipe_decode_latch_pkg::*;
#(
    parameter int XL           = CORE_XL,
    parameter int TRAP_CAUSE_W = CORE_TRAP_CAUSE_W
) (
    input  logic                     g_clk,
    input  logic                     g_resetn,
    input  logic                     flush,
    core_pipe_decode_latch_if.slave  bus
);

    s2_state_e               state_q, state_d;
    logic                    valid_q, valid_d;
    logic [31:0]             instr_q, instr_d;
    logic [XL:0]             pc_q;
    logic [XL:0]             npc_q;
    logic                    i16_q;
    logic                    trap_q;
    logic [TRAP_CAUSE_W-1:0] cause_q;

    logic                    present;
    logic                    halt;
    logic                    load;
    logic                    pd_trap;
    logic [TRAP_CAUSE_W-1:0] pd_cause;

    assign present = bus.s1_i16bit || bus.s1_i32bit;
    assign halt    = (state_q == ST_HALT);
    assign load    = present && (!valid_q || bus.s2_ready) && !flush && !halt;

    // 16-bit wins if fetch ever raised both, so the two eats stay exclusive
    assign bus.s1_eat_2 = load && bus.s1_i16bit;
    assign bus.s1_eat_4 = load && bus.s1_i32bit && !bus.s1_i16bit;

    assign instr_d = bus.s1_i16bit ? {16'h0000, bus.s1_instr[15:0]} : bus.s1_instr;

    core_pipe_predecode #(
        .TRAP_CAUSE_W (TRAP_CAUSE_W)
    ) u_predecode (
        .instr_i  (bus.s1_instr[15:0]),
        .i16bit_i (bus.s1_i16bit),
        .ferr_i   (bus.s1_ferr),
        .trap_o   (pd_trap),
        .cause_o  (pd_cause)
    );

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            state_d = pd_trap ? ST_HALT : ST_FULL;
        end else if (valid_q && bus.s2_ready) begin
            valid_d = 1'b0;
            // A consumed trap leaves the block empty but still halted
            if (!halt) begin
                state_d = ST_EMPTY;
            end
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q <= ST_EMPTY;
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
            npc_q   <= '0;
            i16_q   <= 1'b0;
            trap_q  <= 1'b0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            if (load) begin
                instr_q <= instr_d;
                pc_q    <= bus.s1_pc;
                npc_q   <= bus.s1_npc;
                i16_q   <= bus.s1_i16bit;
                trap_q  <= pd_trap;
                cause_q <= pd_cause;
            end
        end
    end

    assign bus.s2_valid      = valid_q;
    assign bus.s2_instr      = instr_q;
    assign bus.s2_pc         = pc_q;
    assign bus.s2_npc        = npc_q;
    assign bus.s2_i16bit     = i16_q;
    assign bus.s2_trap       = trap_q;
    assign bus.s2_trap_cause = cause_q;

endmodule

// File: tb/tb_core_pipe_decode_latch.sv
// tb/tb_core_pipe_decode_latch.sv - scoreboard bench with a behavioural model of the decode entry latch
module tb_core_pipe_decode_latch;

`ifdef CORE_RVC_EN
    localparam bit RVC = 1'b1;
`else
    localparam bit RVC = 1'b0;
`endif

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] npc;
        bit          i16;
        bit          trap;
        logic [5:0]  cause;
    } exp_t;

    logic g_clk = 1'b0;
    logic g_resetn;
    logic flush;

    core_pipe_decode_latch_if #(.XL(63), .TRAP_CAUSE_W(6)) bus ();

    core_pipe_decode_latch #(.XL(63), .TRAP_CAUSE_W(6)) dut (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .flush    (flush),
        .bus      (bus)
    );

    always #5 g_clk = ~g_clk;

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];
    exp_t pend_e;
    bit   pend_v = 1'b0;
    bit   halted = 1'b0;
    bit   mon_en = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input bit i16, input logic [31:0] ins, input logic [63:0] pc,
                                   input logic [63:0] npc, input logic [1:0] fe);
        exp_t e;
        e.instr = i16 ? (ins & 32'h0000_ffff) : ins;
        e.pc    = pc;
        e.npc   = npc;
        e.i16   = i16;
        e.trap  = 1'b0;
        e.cause = 6'd0;
        if (i16) begin
            if (fe[0]) begin
                e.trap = 1'b1; e.cause = 6'd1;
            end else if (!RVC || ins[15:0] == 16'h0000) begin
                e.trap = 1'b1; e.cause = 6'd2;
            end
        end else if (fe != 2'b00) begin
            e.trap = 1'b1; e.cause = 6'd1;
        end
        return e;
    endfunction

    // One cycle: inputs driven just after the edge, eats checked against the model
    task automatic cycle(input bit i16, input bit i32, input logic [31:0] ins, input logic [63:0] pc,
                         input logic [1:0] fe, input bit rdy, input bit fl);
        bit exp_load;
        @(posedge g_clk);
        if (pend_v) begin
            sb_q.push_back(pend_e);
            pend_v = 1'b0;
        end
        #1;
        bus.s1_i16bit = i16;
        bus.s1_i32bit = i32;
        bus.s1_instr  = ins;
        bus.s1_pc     = pc;
        bus.s1_npc    = pc + (i16 ? 64'd2 : 64'd4);
        bus.s1_ferr   = fe;
        bus.s2_ready  = rdy;
        flush         = fl;
        #1;
        exp_load = (i16 || i32) && (sb_q.size() == 0 || rdy) && !fl && !halted;
        check("eat_2", bus.s1_eat_2, exp_load && i16);
        check("eat_4", bus.s1_eat_4, exp_load && i32);
        if (fl) halted = 1'b0;
        if (exp_load) begin
            pend_e = model(i16, ins, pc, bus.s1_npc, fe);
            pend_v = 1'b1;
            if (pend_e.trap) halted = 1'b1;
        end
    endtask

    // Monitor: front of the scoreboard must be what stage 2 presents
    initial begin
        exp_t e;
        forever begin
            @(negedge g_clk);
            if (mon_en) begin
                check("s2_valid", bus.s2_valid, sb_q.size() != 0);
                if (bus.s2_valid && sb_q.size() != 0) begin
                    e = sb_q[0];
                    check("s2_instr", bus.s2_instr, e.instr);
                    check("s2_pc", bus.s2_pc, e.pc);
                    check("s2_npc", bus.s2_npc, e.npc);
                    check("s2_i16bit", bus.s2_i16bit, e.i16);
                    check("s2_trap", bus.s2_trap, e.trap);
                    check("s2_trap_cause", bus.s2_trap_cause, e.cause);
                    if (bus.s2_ready) void'(sb_q.pop_front());
                end
                if (flush) sb_q.delete();
            end
        end
    end

    initial begin
        bit          i16, i32;
        logic [31:0] ins;
        logic [1:0]  fe;
        logic [63:0] pc;
        g_resetn      = 1'b0;
        flush         = 1'b0;
        bus.s1_i16bit = 1'b0;
        bus.s1_i32bit = 1'b0;
        bus.s1_instr  = '0;
        bus.s1_pc     = '0;
        bus.s1_npc    = '0;
        bus.s1_ferr   = '0;
        bus.s2_ready  = 1'b0;
        repeat (3) @(posedge g_clk);
        #1;
        check("rst_valid", bus.s2_valid, 0);
        check("rst_eat_2", bus.s1_eat_2, 0);
        check("rst_eat_4", bus.s1_eat_4, 0);
        check("rst_instr", bus.s2_instr, 0);
        check("rst_pc", bus.s2_pc, 0);
        check("rst_npc", bus.s2_npc, 0);
        check("rst_i16", bus.s2_i16bit, 0);
        check("rst_trap", bus.s2_trap, 0);
        check("rst_cause", bus.s2_trap_cause, 0);
        g_resetn = 1'b1;
        mon_en   = 1'b1;

        // First load, stall with a pending instruction, then back-to-back
        cycle(0, 1, 32'h0000_0013, 64'h1000_0000, 2'b00, 0, 0);
        cycle(0, 1, 32'h0010_0093, 64'h1000_0004, 2'b00, 0, 0);
        cycle(0, 1, 32'h0010_0093, 64'h1000_0004, 2'b00, 0, 0);
        cycle(0, 1, 32'h0010_0093, 64'h1000_0004, 2'b00, 1, 0);
        // All-zero halfword traps; nothing is eaten until flush
        cycle(1, 0, 32'hffff_0000, 64'h1000_0008, 2'b00, 1, 0);
        cycle(0, 1, 32'h0000_0013, 64'h1000_000a, 2'b00, 0, 0);
        cycle(0, 1, 32'h0000_0013, 64'h1000_000a, 2'b00, 1, 0);
        cycle(0, 1, 32'h0000_0013, 64'h1000_000a, 2'b00, 1, 0);
        cycle(0, 1, 32'h0000_0013, 64'h1000_000a, 2'b00, 0, 1);
        // Upper-half fetch error on a 32-bit instruction
        cycle(0, 1, 32'h0000_0013, 64'h2000_0000, 2'b10, 1, 0);
        cycle(0, 0, 32'h0, 64'h0, 2'b00, 1, 1);
        // Upper-half error ignored for a 16-bit instruction
        cycle(1, 0, 32'hdead_4501, 64'h3000_0000, 2'b10, 1, 0);
        cycle(1, 0, 32'h0000_4501, 64'h3000_0002, 2'b00, 0, 0);
        // Flush together with ready and a pending instruction
        cycle(0, 1, 32'h0000_0013, 64'h3000_0004, 2'b00, 1, 1);
        cycle(0, 1, 32'h0000_0013, 64'h4000_0000, 2'b00, 1, 0);
        cycle(0, 1, 32'h0000_0093, 64'h4000_0004, 2'b00, 1, 1);
        cycle(1, 0, 32'h0000_0001, 64'h4000_0008, 2'b01, 1, 0);
        cycle(0, 0, 32'h0, 64'h0, 2'b00, 1, 1);

        for (int i = 0; i < 400; i++) begin
            i16 = 1'b0;
            i32 = 1'b0;
            case ($urandom_range(0, 3))
                1:       i16 = 1'b1;
                2, 3:    i32 = 1'b1;
                default: ;
            endcase
            ins = $urandom();
            if (i16 && $urandom_range(0, 3) == 0) ins[15:0] = 16'h0000;
            fe = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            pc = {32'h0, $urandom()} & ~64'h1;
            cycle(i16, i32, ins, pc, fe, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
        end

        repeat (3) cycle(0, 0, 32'h0, 64'h0, 2'b00, 1, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/core_pipe_decode_latch.md
# core_pipe_decode_latch

Stage-2 entry register of the pipeline, directly downstream of the fetch stage. It consumes 16/32-bit instructions from the fetch buffer by pulsing the eat-2/eat-4 drain signals. It pre-classifies each instruction (size, fetch fault, trivially illegal encodings) and holds it in a valid/ready register for the decode/execute stage. It blocks further consumption after a trapping instruction and is cleared by control-flow flushes.

## Interface
Parameters:
- `XL`, 63, MSB index of XLEN datapath (from `core_common.svh`).
- `TRAP_CAUSE_W`, 6, width of the trap cause field.

Ports:
- `g_clk`  in  1  global clock.
- `g_resetn`  in  1  reset, synchronous, active-low.
- `flush`  in  1  control-flow change accepted this cycle (`cf_valid && cf_ack`).
- `s1_i16bit`  in  1  fetch presents a 16-bit instruction.
- `s1_i32bit`  in  1  fetch presents a 32-bit instruction.
- `s1_instr`  in  32  instruction bits; the low half is valid for 16-bit.
- `s1_pc`  in  XL+1  instruction PC.
- `s1_npc`  in  XL+1  next sequential PC.
- `s1_ferr`  in  2  fetch error, one bit per halfword (bit 0 = low).
- `s1_eat_2`  out  1  consume 2 bytes from fetch.
- `s1_eat_4`  out  1  consume 4 bytes from fetch.
- `s2_valid`  out  1  stage-2 register holds an instruction.
- `s2_ready`  in  1  downstream accepts this cycle.
- `s2_instr`  out  32  latched instruction; upper 16 bits are zeroed for 16-bit.
- `s2_pc`, `s2_npc`  out  XL+1  latched PCs.
- `s2_i16bit`  out  1  latched instruction is 16-bit.
- `s2_trap`  out  1  latched instruction must trap.
- `s2_trap_cause`  out  TRAP_CAUSE_W  mcause code: 1 = instruction access fault, 2 = illegal instruction.

## Operation
- States:
  - EMPTY: `s2_valid`=0.
  - FULL: `s2_valid`=1.
  - HALT: `s2_valid` may be 0 or 1; a trap instruction has been latched and the block is waiting for a flush.
- Accept condition: `load = (s1_i16bit || s1_i32bit) && (!s2_valid || s2_ready) && !flush && !halt`.
- Eat outputs: `s1_eat_2 = load && s1_i16bit`, `s1_eat_4 = load && s1_i32bit`. These are combinational and are never both 1.
- On `load`, latch instr, pc, npc and size, and compute the trap:
  - 32-bit: `s1_ferr[0] || s1_ferr[1]` gives cause 1.
  - 16-bit: `s1_ferr[0]` gives cause 1; otherwise `s1_instr[15:0]==0` gives cause 2.
  - Access fault has priority over illegal.
- A trapping instruction sets `halt`. No further loads occur until `flush`.
- Transitions:
  - EMPTY→FULL on `load`.
  - FULL→FULL when `s2_ready` and `load` occur together (back-to-back).
  - FULL→EMPTY when `s2_ready` occurs without `load`.
  - Any state→EMPTY on `flush`, which also clears `halt`.
- Simultaneous `flush` and `s2_ready`: the held instruction is considered consumed, the register clears, and nothing new loads.
- Payload registers hold their value when not loading; no clearing is required.
- `s2_trap`/`s2_trap_cause` are qualified only by `s2_valid`.

## Timing
- Reset values: `s2_valid`=0, `halt`=0, `s2_trap`=0, `s2_trap_cause`=0, `s2_i16bit`=0, `s2_instr`=0, `s2_pc`=0, `s2_npc`=0.
- Eat outputs are 0 while reset is asserted, because `!halt` uses the registered value and `s1_*` inputs are 0 from the reset fetch buffer.
- Latency: an instruction presented with `load` in cycle N appears with `s2_valid`=1 in N+1.
- Throughput: one instruction per cycle while `s2_ready`=1.
- `s2_ready` feeds the eat outputs combinationally within one cycle. There is no combinational path from `s1_*` inputs to any `s2_*` output.
- A `flush` in cycle N gives `s2_valid`=0 in N+1. The eat outputs are 0 in cycle N.

## Configuration
- `CORE_RVC_EN`, defined:
  - 16-bit instructions are latched normally.
  - Only an all-zero halfword is illegal.
- `CORE_RVC_EN`, undefined:
  - Every instruction with `s1_i16bit` is still consumed (`s1_eat_2`) so fetch can progress to the trap.
  - It is latched with `s2_trap`=1 and cause 2, unless `s1_ferr[0]` is set, which gives cause 1.
  - `s1_i32bit` behaviour is unchanged.

## Structure
- Trap cause codes (`TRAP_IACCESS`=1, `TRAP_ILLEGAL`=2) and `TRAP_CAUSE_W` go in `core_common.svh` so execute and CSR logic share them.
- One combinational sub-module, `core_pipe_predecode`:
  - Inputs: instr, size, ferr.
  - Outputs: trap, cause.
  - It contains all `CORE_RVC_EN`-dependent logic.
- State and handshake logic live in the top module.

## Test plan
- Reset, then present `s1_i32bit`=1, instr 0x00000013, pc 0x10000000 → `s1_eat_4`=1 in the same cycle; `s2_valid`=1, `s2_instr`=0x00000013, `s2_npc`=0x10000004 in the next cycle.
- `s2_ready`=0 while FULL and a new instr is pending → eats are 0 and the payload is stable. Raise `s2_ready` → back-to-back load; `s2_valid` stays 1 and the new pc is latched.
- 16-bit 0x0000 with RVC enabled → `s2_trap`=1, cause 2. The next instruction is not eaten until `flush`; after flush `s2_valid`=0 in the next cycle.
- 32-bit with `s1_ferr`=2'b10 → cause 1.
- 16-bit 0x4501 with `s1_ferr`=2'b10 → no trap; upper-half error ignored.
- `flush` and `s2_ready` asserted together with an instruction pending → eats are 0 and `s2_valid`=0 next cycle.
- `CORE_RVC_EN` undefined, 16-bit 0x4501 → `s1_eat_2`=1, `s2_trap`=1, cause 2, `s2_instr`=0x00004501.
